// File: rtl/frame_capture_ctrl_if.sv
// Camera-to-FIFO signal bundle for frame_capture_ctrl.
// Latency: n/a (wiring only).
// Backpressure: fifo_full travels toward the capture controller; the camera side has no stall.
//
// Signals:
//   vsync, href, din  camera frame sync (high = blanking), line valid, byte
//   fifo_full         FIFO full flag
//   fifo_wr, fifo_din FIFO write strobe and pixel {first byte, second byte}
// Modports: master = camera/FIFO environment, slave = capture controller.
interface frame_capture_ctrl_if #(
    parameter int DBITS = 8
);
    logic               vsync;
    logic               href;
    logic [DBITS-1:0]   din;
    logic               fifo_full;
    logic               fifo_wr;
    logic [2*DBITS-1:0] fifo_din;

    modport master (
        output vsync, href, din, fifo_full,
        input  fifo_wr, fifo_din
    );

    modport slave (
        input  vsync, href, din, fifo_full,
        output fifo_wr, fifo_din
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms on start, aligns to vsync, packs byte pairs into pixels for the FIFO.
// Latency: fifo_wr/fifo_din appear one cycle after the second byte of a pixel; all outputs registered.
// Backpressure: fifo_full drops the due pixel and sets sticky err_ovf; the camera is never stalled.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   start_i, cont_i        capture request (IDLE only), continuous mode (sampled in DONE)
//   abort_i                return to IDLE next cycle from any busy state, no done pulse
//   cam_if (slave)         vsync/href/din/fifo_full in, fifo_wr/fifo_din out
//   busy_o, done_o         not-IDLE flag, one-cycle end-of-frame pulse
//   err_ovf_o, err_size_o  sticky overflow / geometry errors, cleared when a capture starts
//   pix_cnt_o, line_cnt_o  pixels written in current line, lines completed in frame
// Optional: define FRAME_CAPTURE_DECIMATE_EN for 2:1 decimation in both axes.
module frame_capture_ctrl #(
    parameter int DBITS   = 8,
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int CW      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 cont_i,
    input  logic                 abort_i,
    frame_capture_ctrl_if.slave  cam_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_ovf_o,
    output logic                 err_size_o,
    output logic [CW-1:0]        pix_cnt_o,
    output logic [CW-1:0]        line_cnt_o
);
    // Sensor-side counters get one extra bit so doubled decimation geometry still fits.
    localparam int SW = CW + 1;

`ifdef FRAME_CAPTURE_DECIMATE_EN
    localparam int H_EXP = 2 * H_PIX;
    localparam int V_EXP = 2 * V_LINES;
`else
    localparam int H_EXP = H_PIX;
    localparam int V_EXP = V_LINES;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CAPTURE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic               href_q, href_d;
    logic [DBITS-1:0]   hi_q, hi_d;
    logic               fifo_wr_q, fifo_wr_d;
    logic [2*DBITS-1:0] fifo_din_q, fifo_din_d;
    logic [CW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]      line_cnt_q, line_cnt_d;
    logic [SW-1:0]      seen_q, seen_d;     // complete sensor pixels in this line
    logic [SW-1:0]      sline_q, sline_d;   // sensor lines completed in this frame
    logic               err_ovf_q, err_ovf_d;
    logic               err_size_q, err_size_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               pix_keep, line_keep;

`ifdef FRAME_CAPTURE_DECIMATE_EN
    // Keep even pixels of even sensor lines; index is taken before this pixel is counted.
    assign pix_keep  = ~seen_q[0] & ~sline_q[0];
    assign line_keep = ~sline_q[0];
`else
    assign pix_keep  = 1'b1;
    assign line_keep = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            href_q     <= 1'b0;
            hi_q       <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            seen_q     <= '0;
            sline_q    <= '0;
            err_ovf_q  <= 1'b0;
            err_size_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            href_q     <= href_d;
            hi_q       <= hi_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_din_q <= fifo_din_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            seen_q     <= seen_d;
            sline_q    <= sline_d;
            err_ovf_q  <= err_ovf_d;
            err_size_q <= err_size_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        href_d     = cam_if.href;
        hi_d       = hi_q;
        fifo_wr_d  = 1'b0;
        fifo_din_d = fifo_din_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        seen_d     = seen_q;
        sline_d    = sline_q;
        err_ovf_d  = err_ovf_q;
        err_size_d = err_size_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_ARM;
                    err_ovf_d  = 1'b0;
                    err_size_d = 1'b0;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                end
            end
            // Waiting for blanking first means capture never starts mid-frame.
            S_ARM: begin
                if (cam_if.vsync) state_d = S_SYNC;
            end
            // line_cnt of the previous frame stays visible until here in continuous mode.
            S_SYNC: begin
                if (!cam_if.vsync) begin
                    state_d    = S_CAPTURE;
                    phase_d    = 1'b0;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    seen_d     = '0;
                    sline_d    = '0;
                end
            end
            S_CAPTURE: begin
                if (cam_if.href) begin
                    if (!phase_q) begin
                        hi_d    = cam_if.din;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        seen_d  = seen_q + SW'(seen_q != '1);
                        // Excess pixels beyond H_PIX fall through silently.
                        if (pix_keep && (pix_cnt_q < CW'(H_PIX))) begin
                            if (cam_if.fifo_full) begin
                                err_ovf_d = 1'b1;
                            end else begin
                                fifo_wr_d  = 1'b1;
                                fifo_din_d = {hi_q, cam_if.din};
                                pix_cnt_d  = pix_cnt_q + CW'(pix_cnt_q != '1);
                            end
                        end
                    end
                end else if (href_q) begin
                    // Line end; an odd trailing byte is discarded by the phase reset.
                    phase_d   = 1'b0;
                    if (seen_q != SW'(H_EXP)) err_size_d = 1'b1;
                    seen_d    = '0;
                    pix_cnt_d = '0;
                    sline_d   = sline_q + SW'(sline_q != '1);
                    if (line_keep) line_cnt_d = line_cnt_q + CW'(line_cnt_q != '1);
                    if (sline_d == SW'(V_EXP)) state_d = S_DONE;
                end
                // Blanking before the frame is complete is a short frame.
                if (cam_if.vsync && (state_d == S_CAPTURE)) begin
                    err_size_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = cont_i ? S_ARM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            fifo_wr_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign cam_if.fifo_wr  = fifo_wr_q;
    assign cam_if.fifo_din = fifo_din_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_ovf_o       = err_ovf_q;
    assign err_size_o      = err_size_q;
    assign pix_cnt_o       = pix_cnt_q;
    assign line_cnt_o      = line_cnt_q;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl with H_PIX=4, V_LINES=2, DBITS=8.
// Pixels are pushed to a scoreboard with their expected cycle; a negedge monitor pops and compares.
// Status flags and counters are compared directly against hand-derived values per scenario.
module tb_frame_capture_ctrl;
    localparam int DBITS = 8;
    localparam int H_PIX = 4;
    localparam int V_LINES = 2;
    localparam int CW = 4;

    typedef struct {
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic busy, done, err_ovf, err_size;
    logic [CW-1:0] pix_cnt, line_cnt;

    frame_capture_ctrl_if #(.DBITS(DBITS)) cam_if();

    frame_capture_ctrl #(.DBITS(DBITS), .H_PIX(H_PIX), .V_LINES(V_LINES), .CW(CW)) dut (
        .clock(clock), .reset(reset), .start_i(start), .cont_i(cont), .abort_i(abort),
        .cam_if(cam_if), .busy_o(busy), .done_o(done), .err_ovf_o(err_ovf),
        .err_size_o(err_size), .pix_cnt_o(pix_cnt), .line_cnt_o(line_cnt)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    int   n_total = 0, n_pass = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;
    exp_t exp_q[$];
    logic [7:0] hi_byte;
    int   last_pix;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write must match the oldest expected pixel, in data and in cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (cam_if.fifo_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_data", {16'h0, cam_if.fifo_din}, {16'h0, e.dat});
                    check("wr_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_one_cycle", {31'h0, done_prev}, 32'd0);
            end
            done_prev <= done;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One href cycle; when a write is expected the pixel is {previous byte, this byte}, one cycle later.
    task automatic byte_cycle(input logic [7:0] b, input bit odd, input bit exp_wr);
        exp_t e;
        cam_if.href = 1'b1;
        cam_if.din  = b;
        if (!odd) hi_byte = b;
        else if (exp_wr) begin
            e.dat = {hi_byte, b};
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
    endtask

    // full_pix: pixel index that meets fifo_full (-1 for none).
    task automatic send_line(input int nbytes, input int full_pix);
        int w;
        bit ew;
        w = 0;
        for (int i = 0; i < nbytes; i++) begin
            ew = 1'b0;
            cam_if.fifo_full = 1'b0;
            if (i % 2 == 1) begin
                if ((i / 2) == full_pix) cam_if.fifo_full = 1'b1;
                else if (w < H_PIX) begin
                    ew = 1'b1;
                    w++;
                end
            end
            byte_cycle(8'(i + 1), (i % 2 == 1), ew);
        end
        cam_if.fifo_full = 1'b0;
        last_pix = int'(pix_cnt);
        cam_if.href = 1'b0;
        cam_if.din  = 8'h00;
        ticks(3);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic vsync_pulse();
        cam_if.vsync = 1'b1;
        ticks(2);
        cam_if.vsync = 1'b0;
        ticks(2);
    endtask

    task automatic sb_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        cam_if.vsync = 1'b0;
        cam_if.href = 1'b0;
        cam_if.din = 8'h00;
        cam_if.fifo_full = 1'b0;
        ticks(2);
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_err", {30'h0, err_ovf, err_size}, 0);
        check("rst_cnts", {24'h0, pix_cnt, line_cnt}, 0);
        check("rst_fifo", {15'h0, cam_if.fifo_wr, cam_if.fifo_din}, 0);

        // Normal frame: 0x0102 0x0304 0x0506 0x0708 per line
        d0 = done_cnt;
        start_pulse();
        check("norm_busy", {31'h0, busy}, 1);
        vsync_pulse();
        send_line(8, -1);
        check("norm_pix_l0", 32'(last_pix), 4);
        send_line(8, -1);
        check("norm_done", 32'(done_cnt - d0), 1);
        check("norm_err", {30'h0, err_ovf, err_size}, 0);
        check("norm_idle", {31'h0, busy}, 0);
        check("norm_lines", {28'h0, line_cnt}, 2);
        sb_drained("norm_sb");

        // Mid-frame arm: href activity while waiting for vsync writes nothing
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            start = (i == 1);
            byte_cycle(8'(8'hA0 + i), (i % 2 == 1), 1'b0);
        end
        start = 1'b0;
        cam_if.href = 1'b0;
        ticks(2);
        check("arm_wait_busy", {31'h0, busy}, 1);
        sb_drained("arm_no_wr");
        vsync_pulse();
        send_line(8, -1);
        send_line(8, -1);
        check("arm_done", 32'(done_cnt - d0), 1);
        sb_drained("arm_sb");

        // Overflow on pixel 2 of line 0
        d0 = done_cnt;
        start_pulse();
        check("start_clears_lines", {28'h0, line_cnt}, 0);
        vsync_pulse();
        send_line(8, 2);
        check("ovf_pix_cnt", 32'(last_pix), 3);
        check("ovf_flag", {31'h0, err_ovf}, 1);
        send_line(8, -1);
        check("ovf_size", {31'h0, err_size}, 0);
        check("ovf_done", 32'(done_cnt - d0), 1);
        sb_drained("ovf_sb");

        // Short line of 6 bytes
        d0 = done_cnt;
        start_pulse();
        check("start_clears_ovf", {31'h0, err_ovf}, 0);
        vsync_pulse();
        send_line(6, -1);
        check("short_pix", 32'(last_pix), 3);
        check("short_size", {31'h0, err_size}, 1);
        send_line(8, -1);
        check("short_done", 32'(done_cnt - d0), 1);
        sb_drained("short_sb");

        // Long line of 10 bytes: only 4 written
        start_pulse();
        check("start_clears_size", {31'h0, err_size}, 0);
        vsync_pulse();
        send_line(10, -1);
        check("long_pix", 32'(last_pix), 4);
        check("long_size", {31'h0, err_size}, 1);
        send_line(8, -1);
        sb_drained("long_sb");

        // Short frame: vsync after one line
        d0 = done_cnt;
        start_pulse();
        vsync_pulse();
        send_line(8, -1);
        cam_if.vsync = 1'b1;
        ticks(3);
        cam_if.vsync = 1'b0;
        tick();
        check("sframe_size", {31'h0, err_size}, 1);
        check("sframe_done", 32'(done_cnt - d0), 1);
        check("sframe_lines", {28'h0, line_cnt}, 1);
        check("sframe_idle", {31'h0, busy}, 0);

        // Continuous mode: back-to-back frames without IDLE
        d0 = done_cnt;
        cont = 1'b1;
        start_pulse();
        vsync_pulse();
        send_line(8, -1);
        send_line(8, -1);
        check("cont_done1", 32'(done_cnt - d0), 1);
        check("cont_busy", {31'h0, busy}, 1);
        check("cont_lines_held", {28'h0, line_cnt}, 2);
        cont = 1'b0;
        vsync_pulse();
        check("cont_lines_clr", {28'h0, line_cnt}, 0);
        send_line(8, -1);
        send_line(8, -1);
        check("cont_done2", 32'(done_cnt - d0), 2);
        check("cont_idle", {31'h0, busy}, 0);
        sb_drained("cont_sb");

        // Abort on the second byte of pixel 1 in line 1
        d0 = done_cnt;
        start_pulse();
        vsync_pulse();
        send_line(8, -1);
        byte_cycle(8'h11, 1'b0, 1'b0);
        byte_cycle(8'h12, 1'b1, 1'b1);
        byte_cycle(8'h13, 1'b0, 1'b0);
        abort = 1'b1;
        byte_cycle(8'h14, 1'b1, 1'b0);
        abort = 1'b0;
        check("abort_idle", {31'h0, busy}, 0);
        check("abort_no_wr", {31'h0, cam_if.fifo_wr}, 0);
        for (int i = 4; i < 8; i++) byte_cycle(8'(8'h11 + i), (i % 2 == 1), 1'b0);
        cam_if.href = 1'b0;
        ticks(3);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        sb_drained("abort_sb");

        // Start while busy is ignored: sticky error and line count survive
        d0 = done_cnt;
        start_pulse();
        vsync_pulse();
        send_line(8, 0);
        start_pulse();
        check("busy_start_ovf", {31'h0, err_ovf}, 1);
        check("busy_start_lines", {28'h0, line_cnt}, 1);
        send_line(8, -1);
        check("busy_start_done", 32'(done_cnt - d0), 1);
        sb_drained("busy_start_sb");

        // Async reset mid-line
        start_pulse();
        vsync_pulse();
        byte_cycle(8'h21, 1'b0, 1'b0);
        byte_cycle(8'h22, 1'b1, 1'b1);
        byte_cycle(8'h23, 1'b0, 1'b0);
        check("pre_rst_pix", {28'h0, pix_cnt}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy}, 0);
        check("arst_fifo", {15'h0, cam_if.fifo_wr, cam_if.fifo_din}, 0);
        check("arst_cnts", {24'h0, pix_cnt, line_cnt}, 0);
        check("arst_flags", {29'h0, done, err_ovf, err_size}, 0);
        cam_if.href = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        vsync_pulse();
        check("arst_stays_idle", {31'h0, busy}, 0);
        sb_drained("arst_sb");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
